// File: rtl/jk_reg_bank.sv
// JK register bank on D storage, fed by a valid/ready command FIFO with a gated apply stage.
// Optional saturating bit-toggle counter enabled by defining JK_TOGGLE_CNT_EN.
module jk_reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             apply_en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             upd,
  output logic             busy
`ifdef JK_TOGGLE_CNT_EN
  ,
  output logic [15:0]      toggle_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] mem_j [DEPTH];
  logic [WIDTH-1:0] mem_k [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_j;
  logic [WIDTH-1:0] head_k;
  logic [WIDTH-1:0] q_next;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign busy      = !empty;
  assign push      = cmd_valid && !full;
  assign pop       = apply_en && !empty;

  assign head_j = mem_j[rd_ptr];
  assign head_k = mem_k[rd_ptr];

  // JK characteristic equation applied per bit onto the D registers.
  assign q_next = (head_j & ~q) | (~head_k & q);
  assign qn     = ~q;

  // Storage is not reset; only pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_j[wr_ptr] <= j;
      mem_k[wr_ptr] <= k;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      upd <= 1'b0;
    end else begin
      upd <= pop;
      if (pop) q <= q_next;
    end
  end

`ifdef JK_TOGGLE_CNT_EN
  logic [16:0] cnt_sum;

  assign cnt_sum = {1'b0, toggle_cnt} + 17'($countones(q_next ^ q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_cnt <= '0;
    end else if (pop) begin
      toggle_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`endif

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

A WIDTH-bit JK register bank built on D storage that converts queued per-bit J/K command words into D next-state values. It is the inverse of the D-to-JK conversion used in the flip-flop conversion set: JK semantics (hold/reset/set/toggle) are decoded onto plain D registers. A small command FIFO with valid/ready handshake decouples the command source from a gated apply stage. An optional saturating bit-toggle counter is provided for activity monitoring.

## Interface
- WIDTH, 8, number of JK bits per command word and width of q/qn
- DEPTH, 4, command FIFO depth in entries; power of 2, >= 2

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command word present on j/k
- cmd_ready  output  1  FIFO can accept; equals !full
- j  input  WIDTH  per-bit J command
- k  input  WIDTH  per-bit K command
- apply_en  input  1  when high, one queued command is applied per cycle
- q  output  WIDTH  register bank state
- qn  output  WIDTH  ~q, combinational
- upd  output  1  one-cycle pulse, high in the cycle q shows a newly applied command
- busy  output  1  FIFO non-empty
- toggle_cnt  output  16  saturating count of q bits that changed (only with JK_TOGGLE_CNT_EN)

## Operation
- Push: on rising edge with cmd_valid && cmd_ready, {j,k} written at write pointer; count increments.
- Pop/apply: on rising edge with apply_en && !empty, head entry popped and q <= (j & ~q) | (~k & q) bitwise:
  - j=0,k=0: hold; j=0,k=1: 0; j=1,k=0: 1; j=1,k=1: toggle.
- Push and pop in the same edge: both occur, count unchanged. Only possible when not full (cmd_ready = !full; no push-through-full).
- No bypass: a command pushed into an empty FIFO is not applied in the same edge.
- apply_en low or FIFO empty: q holds, upd low, FIFO contents retained.
- Pointers are log2(DEPTH) bits wrapping modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits, 0..DEPTH.
- full = (count == DEPTH); empty = (count == 0); busy = !empty.
- cmd_valid with j/k containing X is not checked; caller responsibility.

## Timing
- Reset values: q = 0, qn = all ones, cmd_ready = 1, upd = 0, busy = 0, toggle_cnt = 0; FIFO pointers and count = 0 (queued commands discarded).
- Reset asserted mid-operation: all above values take effect immediately (asynchronous), regardless of clk; pending entries lost.
- Latency: command accepted at edge N -> earliest q update at edge N+1, upd high for the cycle following edge N+1.
- Throughput: one command per cycle sustained when apply_en held high (simultaneous push/pop).
- cmd_ready, busy derived from registered count; change only on clk edges or rst.
- upd is registered: high exactly one cycle per applied command, stays high across back-to-back applies.

## Configuration
- JK_TOGGLE_CNT_EN defined: toggle_cnt port present; on each apply, toggle_cnt <= min(toggle_cnt + popcount(q_new ^ q_old), 16'hFFFF); holds at 16'hFFFF once saturated; cleared only by rst.
- JK_TOGGLE_CNT_EN undefined: toggle_cnt port and counter logic absent; all other behaviour identical.

## Test plan
- Reset: assert rst mid-stream with 3 queued entries -> q=8'h00, qn=8'hFF, busy=0, cmd_ready=1 immediately, no later apply of flushed entries.
- Decode: apply_en=1, push {j=8'hF0,k=8'h0F} then {j=8'h00,k=8'hC0} then {j=8'hFF,k=8'hFF} -> q sequence 8'hF0, 8'h30, 8'hCF, upd high three consecutive cycles.
- Full/backpressure: apply_en=0, push 4 commands -> cmd_ready=0 after 4th; 5th cmd_valid held is not accepted; raise apply_en -> entries apply in order, cmd_ready returns 1 after first pop.
- Simultaneous push/pop: FIFO at 2 entries, apply_en=1, cmd_valid=1 for 5 cycles -> count stays 2, q updates every cycle, no command lost or duplicated.
- Hold: push {j=8'h00,k=8'h00} with q=8'hA5 -> q stays 8'hA5, upd pulses once, toggle_cnt unchanged.
- JK_TOGGLE_CNT_EN: from q=0, apply {8'hFF,8'hFF} twice -> toggle_cnt=16; preload near 16'hFFF8 by repeated toggles -> saturates at 16'hFFFF and holds.
